mcp300x_responder: RTL and testbench

Behavioural SPI ADC responder emulating an MCP3004/MCP3008 on the Pmod ADC pins, clocked by the fabric system clock. It watches `cs_n`/`sclk`/`din` from an ADC-reading master, decodes the start/SGL/D2..D0 command, latches a 10-bit result from a per-channel data bus and shifts it out on `dout`. Used for on-board loopback of the ADC reader and as a bench model for the ADC sample path.

---
 rtl/mcp300x_responder.sv | 204 ++++++++++++++++++++
 tb/tb_mcp300x_responder.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/mcp300x_responder.sv
// Purpose: MCP3004/MCP3008 SPI ADC responder, oversampling cs_n/sclk/din on the fabric clock.
// Latency: pin edge to strobe SYNC_STAGES+1 clk, strobe to dout/dout_oe/conv_* 1 clk.
// Backpressure: none; the master paces everything via sclk, cs_n high aborts any frame.
module mcp300x_responder #(
    parameter int NUM_CH      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cs_n,
    input  logic                 sclk,
    input  logic                 din,
    input  logic [NUM_CH*10-1:0] ch_data,
    output logic                 dout,
    output logic                 dout_oe,
    output logic                 conv_valid,
    output logic [2:0]           conv_ch,
    output logic                 conv_sgl,
    output logic [9:0]           conv_data
);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_START,
        CMD,
        SAMPLE,
        NULLB,
        MSB,
        LSB,
        ZERO
    } state_t;

    // MCP3004 ignores D2, so the channel index is folded to two bits
    localparam logic [2:0] CH_MASK = (NUM_CH == 4) ? 3'b011 : 3'b111;

    logic [SYNC_STAGES-1:0] cs_s;
    logic [SYNC_STAGES-1:0] sclk_s;
    logic [SYNC_STAGES-1:0] din_s;
    logic                   sclk_d;
    logic                   rise;
    logic                   fall;
    logic                   din_q;
    logic                   cs_hi;

    state_t     state_q, state_n;
    logic [3:0] cnt_q, cnt_n;
    logic [3:0] cmd_q, cmd_n;
    logic       dout_n, oe_n, vld_n, sgl_n;
    logic [2:0] ch_n;
    logic [9:0] data_n;

    logic [9:0]  ch_arr [8];
    logic [2:0]  sel_pos;
    logic [2:0]  sel_neg;
    logic [10:0] diff;
    logic [9:0]  conv_res;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cs_s   <= '1;
            sclk_s <= '0;
            din_s  <= '0;
            sclk_d <= 1'b0;
            rise   <= 1'b0;
            fall   <= 1'b0;
            din_q  <= 1'b0;
        end else begin
            cs_s   <= {cs_s[SYNC_STAGES-2:0], cs_n};
            sclk_s <= {sclk_s[SYNC_STAGES-2:0], sclk};
            din_s  <= {din_s[SYNC_STAGES-2:0], din};
            sclk_d <= sclk_s[SYNC_STAGES-1];
            rise   <= sclk_s[SYNC_STAGES-1] & ~sclk_d;
            fall   <= ~sclk_s[SYNC_STAGES-1] & sclk_d;
            din_q  <= din_s[SYNC_STAGES-1];
        end
    end

    assign cs_hi = cs_s[SYNC_STAGES-1];

    // Unpopulated channels of the 8-entry view read as zero
    for (genvar g = 0; g < 8; g++) begin : g_ch
        if (g < NUM_CH) begin : g_used
            assign ch_arr[g] = ch_data[g*10 +: 10];
        end else begin : g_unused
            assign ch_arr[g] = '0;
        end
    end

    // Differential: D0 selects which member of the pair is the positive input
    assign sel_pos  = cmd_q[2:0] & CH_MASK;
    assign sel_neg  = {cmd_q[2:1], ~cmd_q[0]} & CH_MASK;
    assign diff     = {1'b0, ch_arr[sel_pos]} - {1'b0, ch_arr[sel_neg]};
    assign conv_res = cmd_q[3] ? ch_arr[sel_pos] : (diff[10] ? 10'd0 : diff[9:0]);

    always_comb begin
        state_n = state_q;
        cnt_n   = cnt_q;
        cmd_n   = cmd_q;
        dout_n  = dout;
        oe_n    = dout_oe;
        vld_n   = 1'b0;
        ch_n    = conv_ch;
        sgl_n   = conv_sgl;
        data_n  = conv_data;
        if (cs_hi) begin
            state_n = IDLE;
            cnt_n   = 4'd0;
            dout_n  = 1'b0;
            oe_n    = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_n = WAIT_START;
                    cnt_n   = 4'd0;
                end
                WAIT_START: begin
                    if (rise && din_q) begin
                        state_n = CMD;
                        cnt_n   = 4'd0;
                    end
                end
                CMD: begin
                    if (rise) begin
                        cmd_n = {cmd_q[2:0], din_q};
                        cnt_n = cnt_q + 4'd1;
                        if (cnt_q == 4'd3) begin
                            state_n = SAMPLE;
                        end
                    end
                end
                SAMPLE: begin
                    if (rise) begin
                        vld_n   = 1'b1;
                        ch_n    = sel_pos;
                        sgl_n   = cmd_q[3];
                        data_n  = conv_res;
                        state_n = NULLB;
                    end
                end
                NULLB: begin
                    if (fall) begin
                        oe_n    = 1'b1;
                        dout_n  = 1'b0;
                        cnt_n   = 4'd9;
                        state_n = MSB;
                    end
                end
                MSB: begin
                    if (fall) begin
                        dout_n = conv_data[cnt_q];
                        if (cnt_q == 4'd0) begin
                            cnt_n   = 4'd1;
                            state_n = LSB;
                        end else begin
                            cnt_n = cnt_q - 4'd1;
                        end
                    end
                end
                LSB: begin
                    // B0 is shared between the two halves, so this pass starts at B1
                    if (fall) begin
                        dout_n = conv_data[cnt_q];
                        if (cnt_q == 4'd9) begin
                            state_n = ZERO;
                        end else begin
                            cnt_n = cnt_q + 4'd1;
                        end
                    end
                end
                ZERO: begin
                    if (fall) begin
                        dout_n = 1'b0;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            cmd_q      <= 4'd0;
            dout       <= 1'b0;
            dout_oe    <= 1'b0;
            conv_valid <= 1'b0;
            conv_ch    <= 3'd0;
            conv_sgl   <= 1'b0;
            conv_data  <= 10'd0;
        end else begin
            state_q    <= state_n;
            cnt_q      <= cnt_n;
            cmd_q      <= cmd_n;
            dout       <= dout_n;
            dout_oe    <= oe_n;
            conv_valid <= vld_n;
            conv_ch    <= ch_n;
            conv_sgl   <= sgl_n;
            conv_data  <= data_n;
        end
    end

endmodule

// File: tb/tb_mcp300x_responder.sv
// Bench for mcp300x_responder: an SPI master drives frames; expected dout bits and
// conversion records are queued at stimulus time and popped when the DUT produces them.
module tb_mcp300x_responder;

    localparam int HALF = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cs_n;
    logic        sclk;
    logic        din;
    logic [79:0] ch8;
    logic [39:0] ch4;

    logic       dout, dout_oe, conv_valid, conv_sgl;
    logic [2:0] conv_ch;
    logic [9:0] conv_data;
    logic       dout4, dout_oe4, conv_valid4, conv_sgl4;
    logic [2:0] conv_ch4;
    logic [9:0] conv_data4;

    int n_tests = 0;
    int n_fail  = 0;

    logic        exp_q  [$];
    logic [13:0] conv_q [$];

    always #5 clk = ~clk;

    mcp300x_responder #(.NUM_CH(8), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n), .cs_n(cs_n), .sclk(sclk), .din(din), .ch_data(ch8),
        .dout(dout), .dout_oe(dout_oe), .conv_valid(conv_valid), .conv_ch(conv_ch),
        .conv_sgl(conv_sgl), .conv_data(conv_data)
    );

    mcp300x_responder #(.NUM_CH(4), .SYNC_STAGES(2)) dut4 (
        .clk(clk), .rst_n(rst_n), .cs_n(cs_n), .sclk(sclk), .din(din), .ch_data(ch4),
        .dout(dout4), .dout_oe(dout_oe4), .conv_valid(conv_valid4), .conv_ch(conv_ch4),
        .conv_sgl(conv_sgl4), .conv_data(conv_data4)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic exp_bit(input logic [9:0] res, input int i);
        logic b;
        b = 1'b0;
        if (i >= 7 && i <= 16) b = res[16-i];
        else if (i >= 17 && i <= 25) b = res[i-16];
        return b;
    endfunction

    always @(negedge clk) begin
        if (conv_valid) begin
            if (conv_q.size() == 0) begin
                chk("conv_unexpected", 1, 0);
            end else begin
                logic [13:0] e;
                e = conv_q.pop_front();
                chk("conv_ch", {29'd0, conv_ch}, {29'd0, e[13:11]});
                chk("conv_sgl", {31'd0, conv_sgl}, {31'd0, e[10]});
                chk("conv_data", {22'd0, conv_data}, {22'd0, e[9:0]});
            end
        end
    end

    task automatic frame(input int nlead, input logic sgl, input logic [2:0] d,
                         input int nrises, input logic [9:0] res, input logic [2:0] ch);
        logic [2:0] dd;
        logic       e;
        dd = d;
        if (nrises >= 6) conv_q.push_back({ch, sgl, res});
        for (int i = 6; i < nrises; i++) exp_q.push_back(exp_bit(res, i));
        cs_n = 1'b0;
        repeat (HALF) @(negedge clk);
        for (int i = -nlead; i < nrises; i++) begin
            if (i == 0) din = 1'b1;
            else if (i == 1) din = sgl;
            else if (i >= 2 && i <= 4) din = dd[4-i];
            else din = 1'b0;
            repeat (HALF) @(negedge clk);
            if (i == 0) chk("oe_before_null", {31'd0, dout_oe}, 0);
            if (i >= 6) begin
                if (exp_q.size() == 0) begin
                    chk("sb_underrun", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk($sformatf("dout_r%0d", i), {31'd0, dout}, {31'd0, e});
                end
                if (i == 6) chk("oe_at_null", {31'd0, dout_oe}, 1);
            end
            sclk = 1'b1;
            if (i == 5) begin
                repeat (3) @(negedge clk);
                chk("conv_valid_early", {31'd0, conv_valid}, 0);
                @(negedge clk);
                chk("conv_valid_at_n2", {31'd0, conv_valid}, 1);
                @(negedge clk);
                chk("conv_valid_width", {31'd0, conv_valid}, 0);
                repeat (HALF - 5) @(negedge clk);
            end else begin
                repeat (HALF) @(negedge clk);
            end
            sclk = 1'b0;
        end
    endtask

    task automatic cs_release();
        cs_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("oe_after_cs", {31'd0, dout_oe}, 0);
        chk("dout_after_cs", {31'd0, dout}, 0);
        @(negedge clk);
        repeat (4) @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        cs_n  = 1'b1;
        sclk  = 1'b0;
        din   = 1'b0;
        ch8   = '0;
        ch4   = '0;
        repeat (3) @(negedge clk);
        chk("rst_dout", {31'd0, dout}, 0);
        chk("rst_oe", {31'd0, dout_oe}, 0);
        chk("rst_valid", {31'd0, conv_valid}, 0);
        chk("rst_ch", {29'd0, conv_ch}, 0);
        chk("rst_sgl", {31'd0, conv_sgl}, 0);
        chk("rst_data", {22'd0, conv_data}, 0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // single-ended ch3, full 30 rises covering MSB, LSB-first repeat and trailing zeros
        ch8[30 +: 10] = 10'h2A5;
        frame(0, 1'b1, 3'b011, 30, 10'h2A5, 3'd3);
        cs_release();

        // differential CH0-CH1 with leading zeros, then negative result clamped
        ch8[0 +: 10]  = 10'd500;
        ch8[10 +: 10] = 10'd200;
        frame(2, 1'b0, 3'b000, 17, 10'h12C, 3'd0);
        cs_release();
        ch8[0 +: 10] = 10'd200;
        ch8[10 +: 10] = 10'd500;
        frame(2, 1'b0, 3'b000, 17, 10'h000, 3'd0);
        cs_release();
        // D0=1 swaps the pair: CH1-CH0
        frame(0, 1'b0, 3'b001, 17, 10'd300, 3'd1);
        cs_release();

        // abort after r10, then immediate new frame; ch_data change mid-shift ignored
        ch8[50 +: 10] = 10'h155;
        frame(0, 1'b1, 3'b101, 11, 10'h155, 3'd5);
        cs_release();
        ch8[70 +: 10] = 10'h3FF;
        fork
            frame(0, 1'b1, 3'b111, 17, 10'h3FF, 3'd7);
            begin
                repeat (HALF * 2 * 9) @(negedge clk);
                ch8[70 +: 10] = 10'h000;
            end
        join
        cs_release();

        // MCP3004 variant folds D2 away: D2=1 D1D0=10 reads channel 2
        ch8[60 +: 10] = 10'h0CC;
        ch4[20 +: 10] = 10'h1B3;
        frame(0, 1'b1, 3'b110, 17, 10'h0CC, 3'd6);
        chk("n4_ch", {29'd0, conv_ch4}, 2);
        chk("n4_sgl", {31'd0, conv_sgl4}, 1);
        chk("n4_data", {22'd0, conv_data4}, 10'h1B3);
        cs_release();

        // reset in the middle of a frame, then a clean frame
        frame(0, 1'b1, 3'b011, 9, 10'h2A5, 3'd3);
        rst_n = 1'b0;
        #1;
        chk("midrst_oe", {31'd0, dout_oe}, 0);
        chk("midrst_dout", {31'd0, dout}, 0);
        chk("midrst_data", {22'd0, conv_data}, 0);
        cs_n = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        frame(0, 1'b1, 3'b011, 17, 10'h2A5, 3'd3);
        cs_release();

        chk("conv_q_drained", conv_q.size(), 0);
        chk("exp_q_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
